sar_search_ctrl: RTL and testbench

Successive-approximation search controller that drives trial operands into a magnitude comparator and consumes its LT/EQ/GT flags to converge on an unknown target value, MSB first. It is the reverse side of the comparator datapath: the comparator turns operands into relation flags, and this block turns relation flags into operands. It sits between a start/result control interface and an external combinational WIDTH-bit comparator, which compares `trial` against the target.

---
 rtl/sar_search_ctrl_if.sv | 45 ++++
 rtl/sar_search_ctrl.sv | 155 +++++++++++++++
 tb/tb_sar_search_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sar_search_ctrl_if.sv
// ---------------------------------------------------------------------------
// sar_search_ctrl_if
//   Bundles the control and comparator signals of the successive-approximation
//   search controller.
//
//   Signals:
//     start  - request a new search (sampled by the controller only in IDLE)
//     lt     - comparator flag: trial <  target
//     eq     - comparator flag: trial == target
//     gt     - comparator flag: trial >  target
//     trial  - registered operand presented to the comparator
//     busy   - high while the controller is searching
//     done   - one-cycle completion pulse
//     result - final value, held until the next accepted start
//     found  - equality was seen during the search (held like result)
//     err    - invalid flag combination aborted the search (held like result)
//
//   Modports:
//     master - the side that requests searches and supplies comparator flags
//     slave  - the search controller itself
// ---------------------------------------------------------------------------
interface sar_search_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             lt;
  logic             eq;
  logic             gt;
  logic [WIDTH-1:0] trial;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             found;
  logic             err;

  modport master (
    output start, lt, eq, gt,
    input  trial, busy, done, result, found, err
  );

  modport slave (
    input  start, lt, eq, gt,
    output trial, busy, done, result, found, err
  );
endinterface

// File: rtl/sar_search_ctrl.sv
// ---------------------------------------------------------------------------
// sar_search_ctrl
//   Successive-approximation search controller. Presents trial operands to an
//   external combinational magnitude comparator, MSB first, and uses the
//   returned lt/eq/gt flags to converge on the largest value <= target.
//
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous active-high reset; forces IDLE with all outputs 0
//     bus  - sar_search_ctrl_if.slave (start, lt/eq/gt in;
//            trial, busy, done, result, found, err out)
//
//   Build option:
//     SAR_EARLY_EXIT_EN - when defined, an eq flag ends the search at once
//                         with result = current trial. When undefined, eq
//                         only sets found and otherwise acts like lt, so every
//                         search takes exactly WIDTH SEARCH cycles.
// ---------------------------------------------------------------------------
module sar_search_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  sar_search_ctrl_if.slave  bus
);

  localparam int KW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] trial_q,  trial_d;
  logic [KW-1:0]    k_q,      k_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             found_q,  found_d;
  logic             err_q,    err_d;

  logic             flags_onehot;
  logic [WIDTH-1:0] trial_dec;

  // Exactly one of the three comparator flags must be asserted.
  assign flags_onehot = ( bus.lt & ~bus.eq & ~bus.gt) |
                        (~bus.lt &  bus.eq & ~bus.gt) |
                        (~bus.lt & ~bus.eq &  bus.gt);

  // Trial value after the decision on bit k: gt clears it, lt/eq keep it.
  always_comb begin
    trial_dec = trial_q;
    if (bus.gt) begin
      trial_dec[k_q] = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    k_d      = k_q;
    result_d = result_q;
    found_d  = found_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          trial_d  = MSB_ONLY;
          k_d      = KW'(WIDTH - 1);
          result_d = '0;
          found_d  = 1'b0;
          err_d    = 1'b0;
          state_d  = ST_SEARCH;
        end
      end

      ST_SEARCH: begin
        if (!flags_onehot) begin
          // Abort with the operand that provoked the bad flags.
          err_d    = 1'b1;
          result_d = trial_q;
          state_d  = ST_DONE;
        end else begin
          if (bus.eq) begin
            found_d = 1'b1;
          end
`ifdef SAR_EARLY_EXIT_EN
          if (bus.eq) begin
            result_d = trial_q;
            state_d  = ST_DONE;
          end else if (k_q == '0) begin
            trial_d  = trial_dec;
            result_d = trial_dec;
            state_d  = ST_DONE;
          end else begin
            trial_d                 = trial_dec;
            trial_d[k_q - KW'(1)]   = 1'b1;
            k_d                     = k_q - KW'(1);
          end
`else
          if (k_q == '0) begin
            trial_d  = trial_dec;
            result_d = trial_dec;
            state_d  = ST_DONE;
          end else begin
            trial_d                 = trial_dec;
            trial_d[k_q - KW'(1)]   = 1'b1;
            k_d                     = k_q - KW'(1);
          end
`endif
        end
      end

      ST_DONE: begin
        // trial is cleared so IDLE never presents a stale operand.
        trial_d = '0;
        k_d     = '0;
        state_d = ST_IDLE;
      end

      default: begin
        trial_d = '0;
        k_d     = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      trial_q  <= '0;
      k_q      <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      k_q      <= k_d;
      result_q <= result_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  assign bus.trial  = trial_q;
  assign bus.busy   = (state_q == ST_SEARCH);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;
  assign bus.found  = found_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sar_search_ctrl
//   Directed bench for sar_search_ctrl (WIDTH=8) with a comparator model
//   against a bench-held target. Expected trial sequences and results are
//   hand-computed tables.
// ---------------------------------------------------------------------------
module tb_sar_search_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] target;
  logic       force_bad;
  int         total;
  int         bad;
  logic [7:0] exp_tr [0:7];

  sar_search_ctrl_if #(.WIDTH(8)) bus ();

  sar_search_ctrl #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator model; force_bad injects the invalid lt=gt=1 combination.
  always_comb begin
    bus.lt = (bus.trial < target);
    bus.eq = (bus.trial == target);
    bus.gt = (bus.trial > target);
    if (force_bad) begin
      bus.lt = 1'b1;
      bus.eq = 1'b0;
      bus.gt = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Runs one search, checking every trial against exp_tr[0..n-1], then DONE
  // and the following IDLE cycles. ign_start pulses start during SEARCH and
  // DONE to show it is neither honoured nor queued.
  task automatic run_search(input logic [7:0] tgt, input int n,
                            input logic [7:0] exp_res, input logic exp_found,
                            input logic ign_start);
    target = tgt;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk("trial", {24'd0, bus.trial}, {24'd0, exp_tr[i]});
      chk("busy",  {31'd0, bus.busy},  32'd1);
      chk("done_low", {31'd0, bus.done}, 32'd0);
      bus.start = (ign_start && i == 2);
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("done",   {31'd0, bus.done},   32'd1);
    chk("busy_done", {31'd0, bus.busy}, 32'd0);
    chk("result", {24'd0, bus.result}, {24'd0, exp_res});
    chk("found",  {31'd0, bus.found},  {31'd0, exp_found});
    chk("err",    {31'd0, bus.err},    32'd0);
    bus.start = ign_start;
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_pulse", {31'd0, bus.done},   32'd0);
    chk("idle_busy",  {31'd0, bus.busy},   32'd0);
    chk("idle_trial", {24'd0, bus.trial},  32'd0);
    chk("held_result", {24'd0, bus.result}, {24'd0, exp_res});
    @(negedge clk);
    chk("no_restart", {31'd0, bus.busy}, 32'd0);
    $display("search target=0x%02h cycles=%0d result=0x%02h found=%0d err=%0d",
             tgt, n, bus.result, bus.found, bus.err);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    force_bad = 1'b0;
    target    = 8'h00;
    bus.start = 1'b0;
    rst       = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_trial",  {24'd0, bus.trial},  32'd0);
    chk("rst_busy",   {31'd0, bus.busy},   32'd0);
    chk("rst_done",   {31'd0, bus.done},   32'd0);
    chk("rst_result", {24'd0, bus.result}, 32'd0);
    chk("rst_found",  {31'd0, bus.found},  32'd0);
    chk("rst_err",    {31'd0, bus.err},    32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Target 0x5A
    exp_tr = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};
`ifdef SAR_EARLY_EXIT_EN
    run_search(8'h5A, 7, 8'h5A, 1'b1, 1'b0);
`else
    run_search(8'h5A, 8, 8'h5A, 1'b1, 1'b0);
`endif

    // Target 0x00: every trial is gt
    exp_tr = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    run_search(8'h00, 8, 8'h00, 1'b0, 1'b0);

    // Target 0xFF: every trial is lt until the final one is eq
    exp_tr = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    run_search(8'hFF, 8, 8'hFF, 1'b1, 1'b0);

    // Target 0x37, with start pulsed during SEARCH and DONE
    // 80 gt->00+40; 40 gt->00+20; 20 lt->20+10=30; 30 lt->38; 38 gt->34;
    // 34 lt->36; 36 lt->37; 37 eq -> result 37
    exp_tr = '{8'h80, 8'h40, 8'h20, 8'h30, 8'h38, 8'h34, 8'h36, 8'h37};
    run_search(8'h37, 8, 8'h37, 1'b1, 1'b1);

    // Invalid flags on the second SEARCH cycle
    target = 8'h5A;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("inv_trial0", {24'd0, bus.trial}, 32'h80);
    @(negedge clk);
    chk("inv_trial1", {24'd0, bus.trial}, 32'h40);
    force_bad = 1'b1;
    @(negedge clk);
    force_bad = 1'b0;
    chk("inv_done",   {31'd0, bus.done},   32'd1);
    chk("inv_err",    {31'd0, bus.err},    32'd1);
    chk("inv_result", {24'd0, bus.result}, 32'h40);
    chk("inv_found",  {31'd0, bus.found},  32'd0);
    @(negedge clk);
    chk("inv_idle",   {31'd0, bus.busy},   32'd0);
    chk("inv_err_held", {31'd0, bus.err},  32'd1);
    $display("search target=0x5A invalid flags result=0x%02h err=%0d", bus.result, bus.err);

    // Asynchronous reset during the 4th SEARCH cycle
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rstm_err_clr", {31'd0, bus.err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rstm_trial_pre", {24'd0, bus.trial}, 32'h50);
    chk("rstm_busy_pre",  {31'd0, bus.busy},  32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstm_trial",  {24'd0, bus.trial},  32'd0);
    chk("rstm_busy",   {31'd0, bus.busy},   32'd0);
    chk("rstm_done",   {31'd0, bus.done},   32'd0);
    chk("rstm_result", {24'd0, bus.result}, 32'd0);
    chk("rstm_found",  {31'd0, bus.found},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstm_idle", {31'd0, bus.busy}, 32'd0);
    $display("reset mid-search trial=0x%02h busy=%0d", bus.trial, bus.busy);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
